ip4_axi_rd_arb: RTL and testbench

Round-robin arbiter that shares the core's AXI master read channels (AR/R on axim) between NREQ internal read requesters (e.g. per-PB fetch and DMA engines).
- AR: grants one requester at a time and tags the AXI ID with the requester index.
- R: routes each beat back to the owning requester by that tag.
- Caps total outstanding bursts at MAXOUT.
- Sits inside ip4_rtl_core between the requesters and the axim interface.

---
 rtl/ip4_axi_rd_arb.sv | 206 ++++++++++++++++++++
 tb/tb_ip4_axi_rd_arb.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip4_axi_rd_arb.sv
// Round-robin arbiter sharing one AXI read master (AR/R) among NREQ internal requesters.
// Latency: AR 1 cycle from req_arvalid to m_arvalid (one AR per 2 cycles); R routing is combinational.
// Backpressure: AR held stable in ISSUE until m_arready; m_rready follows the tagged requester's rready.
module ip4_axi_rd_arb #(
   parameter int NREQ   = 4,
   parameter int AW     = 32,
   parameter int DW     = 64,
   parameter int IDW    = 4,
   parameter int MAXOUT = 8,
   localparam int RIW   = $clog2(NREQ),
   localparam int CW    = $clog2(MAXOUT + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // requester AR side
   input  logic [NREQ-1:0]       req_arvalid,
   output logic [NREQ-1:0]       req_arready,
   input  logic [NREQ*AW-1:0]    req_araddr,
   input  logic [NREQ*4-1:0]     req_arlen,
   input  logic [NREQ*IDW-1:0]   req_arid,
   // requester R side
   output logic [NREQ-1:0]       req_rvalid,
   input  logic [NREQ-1:0]       req_rready,
   output logic [DW-1:0]         req_rdata,
   output logic [1:0]            req_rresp,
   output logic                  req_rlast,
   output logic [IDW-1:0]        req_rid,
   // AXI master AR
   output logic                  m_arvalid,
   input  logic                  m_arready,
   output logic [AW-1:0]         m_araddr,
   output logic [3:0]            m_arlen,
   output logic [IDW+RIW-1:0]    m_arid,
   // AXI master R
   input  logic                  m_rvalid,
   output logic                  m_rready,
   input  logic [DW-1:0]         m_rdata,
   input  logic [1:0]            m_rresp,
   input  logic                  m_rlast,
   input  logic [IDW+RIW-1:0]    m_rid,
   // status
   output logic [CW-1:0]         outstanding,
   output logic                  err
);

   // AR payload as presented on the master port; the ID carries the requester index on top
   typedef struct packed {
      logic [AW-1:0]      addr;
      logic [3:0]         len;
      logic [IDW+RIW-1:0] id;
   } ar_t;

   typedef enum logic {
      ST_IDLE,
      ST_ISSUE
   } state_t;

   state_t          state_q, state_d;
   ar_t             ar_q, ar_sel;
   logic [RIW-1:0]  last_grant_q;
   logic [RIW-1:0]  gnt_idx;
   logic            gnt_vld;
   logic            grant;
   logic            ar_hs;
   logic            full;
   logic [CW-1:0]   outstanding_q;
   logic            err_q;

   logic [RIW-1:0]  sel;
   logic            sel_ok;
   logic [NREQ-1:0] rdy_sh;
   logic            r_hs;
   logic            rlast_hs;
   logic            bad_beat;
   logic            underflow;

   assign full = (outstanding_q == CW'(MAXOUT));

   // Round-robin search: first valid requester after last_grant, wrapping; nearest candidate wins
   always_comb begin
      logic [RIW-1:0] cand;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = RIW'((int'(last_grant_q) + k) % NREQ);
         if (req_arvalid[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   // Payload of the requester currently winning arbitration, ID tagged with its index
   always_comb begin
      ar_sel      = '0;
      ar_sel.addr = req_araddr[int'(gnt_idx)*AW +: AW];
      ar_sel.len  = req_arlen[int'(gnt_idx)*4 +: 4];
      ar_sel.id   = {gnt_idx, req_arid[int'(gnt_idx)*IDW +: IDW]};
   end

   // AR state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // AR next state and grant: grant only from IDLE with room left; ISSUE waits for the slave
   always_comb begin
      state_d     = state_q;
      req_arready = '0;
      grant       = 1'b0;
      ar_hs       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (gnt_vld && !full) begin
               grant                = 1'b1;
               req_arready[gnt_idx] = 1'b1;
               state_d              = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (m_arready) begin
               ar_hs   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Capture the granted request; payload stays frozen while the AR waits in ISSUE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ar_q         <= '0;
         last_grant_q <= RIW'(NREQ - 1);
      end else if (grant) begin
         ar_q         <= ar_sel;
         last_grant_q <= gnt_idx;
      end
   end

   assign m_arvalid = (state_q == ST_ISSUE);
   assign m_araddr  = ar_q.addr;
   assign m_arlen   = ar_q.len;
   assign m_arid    = ar_q.id;

   // R routing: the ID tag selects the owning requester; data/resp/last/id are broadcast
   assign sel = m_rid[IDW+RIW-1:IDW];

   generate
      if (NREQ == (1 << RIW)) begin : g_pow2
         assign sel_ok = 1'b1;
      end else begin : g_npow2
         assign sel_ok = (sel < RIW'(NREQ));
      end
   endgenerate

   // Steer valid to the tagged requester; an impossible tag is sunk so the bus cannot lock up
   always_comb begin
      req_rvalid = '0;
      m_rready   = 1'b1;
      rdy_sh     = req_rready >> sel;
      if (sel_ok) begin
         req_rvalid[sel] = m_rvalid;
         m_rready        = rdy_sh[0];
      end
   end

   assign req_rdata = m_rdata;
   assign req_rresp = m_rresp;
   assign req_rlast = m_rlast;
   assign req_rid   = m_rid[IDW-1:0];

   assign r_hs      = m_rvalid && m_rready;
   assign rlast_hs  = r_hs && m_rlast;
   assign bad_beat  = m_rvalid && !sel_ok;
   assign underflow = rlast_hs && (outstanding_q == '0);

   // Outstanding-burst count: +1 per AR handshake, -1 per last beat, net zero when both coincide
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding_q <= '0;
      end else if (ar_hs && !rlast_hs) begin
         outstanding_q <= outstanding_q + CW'(1);
      end else if (!ar_hs && rlast_hs && (outstanding_q != '0)) begin
         outstanding_q <= outstanding_q - CW'(1);
      end
   end

   // Sticky protocol error: unroutable beat or a last beat with nothing outstanding
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (bad_beat || underflow) begin
         err_q <= 1'b1;
      end
   end

   assign outstanding = outstanding_q;
   assign err         = err_q;

endmodule

// File: tb/tb_ip4_axi_rd_arb.sv
module tb_ip4_axi_rd_arb;
   localparam int N   = 4;
   localparam int AW  = 32;
   localparam int DW  = 64;
   localparam int IDW = 4;
   localparam int MO  = 2;
   localparam int RIW = 2;
   localparam int CW  = 2;
   localparam int TW  = IDW + RIW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // main instance: NREQ=4, MAXOUT=2
   logic [N-1:0]     req_arvalid, req_arready, req_rvalid, req_rready;
   logic [N*AW-1:0]  req_araddr;
   logic [N*4-1:0]   req_arlen;
   logic [N*IDW-1:0] req_arid;
   logic [DW-1:0]    req_rdata;
   logic [1:0]       req_rresp;
   logic             req_rlast;
   logic [IDW-1:0]   req_rid;
   logic             m_arvalid, m_arready;
   logic [AW-1:0]    m_araddr;
   logic [3:0]       m_arlen;
   logic [TW-1:0]    m_arid;
   logic             m_rvalid, m_rready;
   logic [DW-1:0]    m_rdata;
   logic [1:0]       m_rresp;
   logic             m_rlast;
   logic [TW-1:0]    m_rid;
   logic [CW-1:0]    outstanding;
   logic             err;

   // second instance: NREQ=3 (non-power-of-2 tag space), MAXOUT=8
   logic [2:0]       b_arvalid, b_arready, b_rvalid, b_rready;
   logic [3*AW-1:0]  b_araddr;
   logic [11:0]      b_arlen;
   logic [11:0]      b_arid;
   logic [DW-1:0]    b_rdata;
   logic [1:0]       b_rresp;
   logic             b_rlast;
   logic [IDW-1:0]   b_rid;
   logic             b_m_arvalid, b_m_arready;
   logic [AW-1:0]    b_m_araddr;
   logic [3:0]       b_m_arlen;
   logic [TW-1:0]    b_m_arid;
   logic             b_m_rvalid, b_m_rready;
   logic [DW-1:0]    b_m_rdata;
   logic [1:0]       b_m_rresp;
   logic             b_m_rlast;
   logic [TW-1:0]    b_m_rid;
   logic [3:0]       b_outstanding;
   logic             b_err;

   ip4_axi_rd_arb #(.NREQ(N), .AW(AW), .DW(DW), .IDW(IDW), .MAXOUT(MO)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_arvalid(req_arvalid), .req_arready(req_arready), .req_araddr(req_araddr),
      .req_arlen(req_arlen), .req_arid(req_arid),
      .req_rvalid(req_rvalid), .req_rready(req_rready), .req_rdata(req_rdata),
      .req_rresp(req_rresp), .req_rlast(req_rlast), .req_rid(req_rid),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
      .m_arlen(m_arlen), .m_arid(m_arid),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
      .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rid(m_rid),
      .outstanding(outstanding), .err(err)
   );

   ip4_axi_rd_arb #(.NREQ(3), .AW(AW), .DW(DW), .IDW(IDW), .MAXOUT(8)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_arvalid(b_arvalid), .req_arready(b_arready), .req_araddr(b_araddr),
      .req_arlen(b_arlen), .req_arid(b_arid),
      .req_rvalid(b_rvalid), .req_rready(b_rready), .req_rdata(b_rdata),
      .req_rresp(b_rresp), .req_rlast(b_rlast), .req_rid(b_rid),
      .m_arvalid(b_m_arvalid), .m_arready(b_m_arready), .m_araddr(b_m_araddr),
      .m_arlen(b_m_arlen), .m_arid(b_m_arid),
      .m_rvalid(b_m_rvalid), .m_rready(b_m_rready), .m_rdata(b_m_rdata),
      .m_rresp(b_m_rresp), .m_rlast(b_m_rlast), .m_rid(b_m_rid),
      .outstanding(b_outstanding), .err(b_err)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // requester-side payload tables, packed onto the buses before every cycle
   logic [AW-1:0]  a_addr [N];
   logic [3:0]     a_len  [N];
   logic [IDW-1:0] a_id   [N];

   // reference model: pending AR record, rotating pointer, burst count, sticky error
   bit             mb_busy;
   logic [AW-1:0]  mb_addr;
   logic [3:0]     mb_len;
   logic [TW-1:0]  mb_id;
   int             mb_last;
   int             mb_outs;
   bit             mb_err;
   int             ex_gnt;
   int             ex_tag;
   logic [N-1:0]   ex_arready;
   logic [N-1:0]   ex_rvalid;
   logic           ex_mrready;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pack();
      for (int i = 0; i < N; i++) begin
         req_araddr[i*AW +: AW]  = a_addr[i];
         req_arlen[i*4 +: 4]     = a_len[i];
         req_arid[i*IDW +: IDW]  = a_id[i];
      end
   endtask

   task automatic model_reset();
      mb_busy = 0; mb_addr = '0; mb_len = '0; mb_id = '0;
      mb_last = N - 1; mb_outs = 0; mb_err = 0;
   endtask

   task automatic model_comb();
      ex_gnt = -1;
      if (!mb_busy && mb_outs < MO) begin
         for (int k = 1; k <= N; k++) begin
            if (ex_gnt < 0 && req_arvalid[(mb_last + k) % N]) ex_gnt = (mb_last + k) % N;
         end
      end
      ex_arready = '0;
      if (ex_gnt >= 0) ex_arready[ex_gnt] = 1'b1;
      ex_tag    = int'(m_rid) / (1 << IDW);
      ex_rvalid = '0;
      ex_mrready = 1'b1;
      if (ex_tag < N) begin
         ex_rvalid[ex_tag] = m_rvalid;
         ex_mrready        = req_rready[ex_tag];
      end
   endtask

   task automatic model_clk();
      bit ar_hs, last_hs;
      ar_hs   = mb_busy && m_arready;
      last_hs = m_rvalid && ex_mrready && m_rlast;
      if (last_hs && mb_outs == 0) mb_err = 1;
      if (m_rvalid && ex_tag >= N) mb_err = 1;
      if (ar_hs && !last_hs) mb_outs++;
      else if (!ar_hs && last_hs && mb_outs > 0) mb_outs--;
      if (ar_hs) mb_busy = 0;
      if (ex_gnt >= 0) begin
         mb_busy = 1;
         mb_addr = a_addr[ex_gnt];
         mb_len  = a_len[ex_gnt];
         mb_id   = TW'((ex_gnt << IDW) + int'(a_id[ex_gnt]));
         mb_last = ex_gnt;
      end
   endtask

   task automatic check_all();
      chk("arready", 64'(req_arready), 64'(ex_arready));
      chk("m_arvalid", 64'(m_arvalid), 64'(mb_busy));
      chk("m_araddr", 64'(m_araddr), 64'(mb_addr));
      chk("m_arlen", 64'(m_arlen), 64'(mb_len));
      chk("m_arid", 64'(m_arid), 64'(mb_id));
      chk("rvalid", 64'(req_rvalid), 64'(ex_rvalid));
      chk("m_rready", 64'(m_rready), 64'(ex_mrready));
      chk("outstanding", 64'(outstanding), 64'(mb_outs));
      chk("err", 64'(err), 64'(mb_err));
      chk("rdata", req_rdata, m_rdata);
      chk("rmeta", 64'({req_rresp, req_rlast, req_rid}), 64'({m_rresp, m_rlast, m_rid[IDW-1:0]}));
   endtask

   // inputs are set at posedge+1; check combinational view at posedge+2
   task automatic settle();
      pack();
      #1;
      model_comb();
      check_all();
   endtask

   task automatic clk_edge();
      @(posedge clk);
      model_clk();
      #1;
   endtask

   task automatic idle_inputs();
      req_arvalid = '0; req_rready = '0; m_arready = 0;
      m_rvalid = 0; m_rlast = 0; m_rid = '0; m_rdata = '0; m_rresp = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      pack();
      rst_n = 0;
      #1;
      model_reset();
      model_comb();
      check_all();
      chk("rst_outstanding", 64'(outstanding), 64'd0);
      chk("rst_arvalid", 64'(m_arvalid), 64'd0);
      @(posedge clk);
      #3;
      rst_n = 1;
      settle();
      clk_edge();
   endtask

   task automatic rbeat(input logic [TW-1:0] rid, input logic last, input logic [N-1:0] rdy);
      m_rvalid = 1; m_rid = rid; m_rlast = last; req_rready = rdy;
      m_rdata = {$urandom, $urandom}; m_rresp = 2'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      int ng, gi, found;
      int g_idx [8];
      int g_cyc [8];
      for (int i = 0; i < N; i++) begin
         a_addr[i] = '0; a_len[i] = '0; a_id[i] = '0;
      end
      b_arvalid = '0; b_rready = '0; b_araddr = '0; b_arlen = '0; b_arid = '0;
      b_m_arready = 0; b_m_rvalid = 0; b_m_rdata = '0; b_m_rresp = '0; b_m_rlast = 0; b_m_rid = '0;
      do_reset();
      chk("b_rst_arvalid", 64'(b_m_arvalid), 64'd0);
      chk("b_rst_outstanding", 64'(b_outstanding), 64'd0);
      chk("b_rst_err", 64'(b_err), 64'd0);

      // single request from requester 2, then a 4-beat burst back
      a_addr[2] = 32'h0000_1000; a_len[2] = 4'd3; a_id[2] = 4'd5;
      req_arvalid = 4'b0100; m_arready = 1;
      settle();
      chk("t1_arready", 64'(req_arready), 64'h4);
      clk_edge();
      req_arvalid = '0;
      settle();
      chk("t1_arvalid", 64'(m_arvalid), 64'd1);
      chk("t1_arid", 64'(m_arid), 64'h25);
      chk("t1_araddr", 64'(m_araddr), 64'h1000);
      chk("t1_arready_low", 64'(req_arready), 64'd0);
      clk_edge();
      for (int b = 0; b < 4; b++) begin
         rbeat(6'h25, (b == 3), 4'b1111);
         settle();
         chk("t1_rvalid", 64'(req_rvalid), 64'h4);
         if (b == 0) chk("t1_out_1", 64'(outstanding), 64'd1);
         clk_edge();
      end
      m_rvalid = 0; m_rlast = 0;
      settle();
      chk("t1_out_0", 64'(outstanding), 64'd0);
      clk_edge();

      // fairness: all four request continuously
      do_reset();
      for (int i = 0; i < N; i++) begin
         a_addr[i] = 32'h100 * i; a_len[i] = 4'(i); a_id[i] = 4'(i + 8);
      end
      req_arvalid = 4'b1111; m_arready = 1;
      ng = 0;
      for (int cyc = 0; cyc < 40 && ng < 8; cyc++) begin
         if (mb_outs > 0) rbeat(6'h00, 1'b1, 4'b1111);
         else m_rvalid = 0;
         settle();
         if (req_arready != '0) begin
            gi = -1;
            for (int i = 0; i < N; i++) if (req_arready[i]) gi = i;
            g_idx[ng] = gi; g_cyc[ng] = cyc; ng++;
         end
         clk_edge();
      end
      chk("fair_count", 64'(ng), 64'd8);
      for (int i = 0; i < 8 && i < ng; i++) chk("fair_order", 64'(g_idx[i]), 64'(i % 4));
      for (int i = 1; i < 8 && i < ng; i++) chk("fair_spacing", 64'(g_cyc[i] - g_cyc[i-1]), 64'd2);

      // backpressure: slave stalls 5 cycles, handshake on the 6th
      do_reset();
      a_addr[1] = 32'hA5A5_0040; a_len[1] = 4'd7; a_id[1] = 4'd9;
      req_arvalid = 4'b0010; m_arready = 0;
      settle();
      chk("bp_grant", 64'(req_arready), 64'h2);
      clk_edge();
      req_arvalid = 4'b1000;
      for (int c = 1; c <= 5; c++) begin
         settle();
         chk("bp_arvalid", 64'(m_arvalid), 64'd1);
         chk("bp_araddr", 64'(m_araddr), 64'hA5A5_0040);
         chk("bp_arid", 64'(m_arid), 64'h19);
         chk("bp_no_arready", 64'(req_arready), 64'd0);
         clk_edge();
      end
      m_arready = 1; req_arvalid = '0;
      settle();
      clk_edge();
      settle();
      chk("bp_done", 64'({m_arvalid, outstanding}), 64'({1'b0, 2'd1}));
      clk_edge();

      // outstanding cap of 2 with three requesters and no read data
      do_reset();
      req_arvalid = 4'b0111; m_arready = 1;
      ng = 0;
      for (int c = 0; c < 10; c++) begin
         settle();
         if (req_arready != '0) ng++;
         clk_edge();
         req_arvalid = req_arvalid & ~ex_arready;
      end
      settle();
      chk("cap_grants", 64'(ng), 64'd2);
      chk("cap_outstanding", 64'(outstanding), 64'd2);
      chk("cap_stalled", 64'({req_arvalid, req_arready}), 64'({4'b0100, 4'b0000}));
      clk_edge();
      rbeat(6'h01, 1'b1, 4'b0001);
      settle();
      clk_edge();
      m_rvalid = 0; m_rlast = 0;
      found = 0;
      for (int c = 0; c < 2 && found == 0; c++) begin
         settle();
         if (req_arready == 4'b0100) found = 1;
         clk_edge();
      end
      chk("cap_third_issues", 64'(found), 64'd1);
      req_arvalid = '0;
      settle();
      clk_edge();

      // AR handshake and last beat on the same edge at outstanding=1
      do_reset();
      req_arvalid = 4'b0001; m_arready = 0;
      settle(); clk_edge();
      req_arvalid = '0; m_arready = 1;
      settle(); clk_edge();
      req_arvalid = 4'b0010;
      settle();
      chk("sim_grant", 64'(req_arready), 64'h2);
      clk_edge();
      req_arvalid = '0;
      rbeat(6'h00, 1'b1, 4'b1111);
      settle();
      chk("sim_pre", 64'({m_arvalid, outstanding}), 64'({1'b1, 2'd1}));
      clk_edge();
      m_rvalid = 0; m_rlast = 0;
      settle();
      chk("sim_outstanding", 64'(outstanding), 64'd1);
      clk_edge();

      // underflow, then reset while an AR is waiting in ISSUE
      do_reset();
      rbeat(6'h15, 1'b1, 4'b1111);
      settle(); clk_edge();
      m_rvalid = 0; m_rlast = 0;
      settle();
      chk("uf_err", 64'(err), 64'd1);
      chk("uf_outstanding", 64'(outstanding), 64'd0);
      clk_edge();
      req_arvalid = 4'b0001; m_arready = 0;
      settle(); clk_edge();
      req_arvalid = '0;
      settle();
      chk("issue_before_rst", 64'({m_arvalid, err}), 64'({1'b1, 1'b1}));
      rst_n = 0;
      #1;
      chk("rst_mid_arvalid", 64'(m_arvalid), 64'd0);
      chk("rst_mid_err", 64'(err), 64'd0);
      do_reset();

      // randomized traffic against the model
      for (int cyc = 0; cyc < 400; cyc++) begin
         req_arvalid = req_arvalid & ~ex_arready;
         for (int i = 0; i < N; i++) begin
            if (!req_arvalid[i] && $urandom_range(0, 2) == 0) begin
               req_arvalid[i] = 1'b1;
               a_addr[i] = $urandom; a_len[i] = 4'($urandom); a_id[i] = IDW'($urandom);
            end
         end
         m_arready = ($urandom_range(0, 3) != 0);
         if (mb_outs > 0 && $urandom_range(0, 1) == 1)
            rbeat(TW'($urandom), ($urandom_range(0, 2) == 0), N'($urandom));
         else begin
            m_rvalid = 0; m_rid = TW'($urandom); m_rlast = 1'($urandom); req_rready = N'($urandom);
         end
         settle();
         clk_edge();
      end
      idle_inputs();

      // NREQ=3 instance: wrap-around grant, routing, unroutable tag
      b_arvalid = 3'b110; b_arid = 12'h0C0; b_araddr = '0; b_arlen = 12'h000;
      #1;
      chk("b_grant", 64'(b_arready), 64'h2);
      @(posedge clk); #1;
      b_arvalid = '0; b_m_arready = 1;
      #1;
      chk("b_arid", 64'(b_m_arid), 64'h1C);
      @(posedge clk); #1;
      b_m_arready = 0;
      #1;
      chk("b_outstanding", 64'(b_outstanding), 64'd1);
      b_m_rvalid = 1; b_m_rid = 6'h27; b_m_rlast = 0; b_rready = 3'b100;
      #1;
      chk("b_route", 64'({b_rvalid, b_m_rready, b_rid}), 64'({3'b100, 1'b1, 4'h7}));
      b_rready = 3'b011;
      #1;
      chk("b_route_stall", 64'(b_m_rready), 64'd0);
      b_m_rid = 6'h31; b_rready = '0;
      #1;
      chk("b_badtag", 64'({b_rvalid, b_m_rready, b_err}), 64'({3'b000, 1'b1, 1'b0}));
      @(posedge clk); #1;
      b_m_rvalid = 0;
      #1;
      chk("b_badtag_err", 64'({b_err, b_outstanding}), 64'({1'b1, 4'd1}));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
